round_ctrl: RTL and testbench
=============================

Name: round_ctrl

Overview:
- Game-round sequencer for the factorization battle.
- Requests a problem, opens the answer window, and consumes the 2-bit win/lose code from the judge (00 none, 01 self win, 10 enemy win, 11 draw).
- Applies damage to both HP counters and ends the game when a player reaches zero HP.
- Sits between the problem generator / answer checker and the HP display.

Parameters:
- HP_W, 4, width of HP counters
- HP_INIT, 5, HP loaded at game start (1..2^HP_W-1)
- DMG, 1, HP removed per lost round
- TIMEOUT_CYC, 1024, answer-window length in cycles (>=2)
- GAP_CYC, 8, idle cycles between rounds (>=2; lets the judge return to 00)
- RND_W, 8, round counter width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- START  in  1  start/restart request, level sampled
- PROB_REQ  out  1  new-problem request, held until acknowledged
- PROB_RDY  in  1  problem-generator acknowledge
- WL_IN  in  2  judge result code
- ANS_EN  out  1  answer input enabled (high only in WAIT)
- MY_HP  out  HP_W  own HP
- EN_HP  out  HP_W  enemy HP
- ROUND_CNT  out  RND_W  completed rounds
- RESULT  out  2  last round result (00 timeout, 01, 10, 11)
- RESULT_VLD  out  1  one-cycle pulse when RESULT updates
- GAME_OVER  out  1  high in OVER
- WINNER  out  2  01 self, 10 enemy, 11 both zero; 00 when not over

Behaviour:
- Reset (RST=0, async): state IDLE; all outputs 0, including MY_HP, EN_HP, ROUND_CNT and RESULT. Reset mid-round aborts the round immediately; no HP change is applied.
- All outputs are registered.
- States: IDLE, LOAD, REQ, WAIT, APPLY, CHECK, GAP, OVER.
- IDLE: START=1 -> LOAD.
- LOAD (1 cycle):
  - MY_HP=EN_HP=HP_INIT, ROUND_CNT=0, RESULT=00, WINNER=00.
  - -> REQ.
- REQ:
  - PROB_REQ=1 from the cycle after entry until the cycle PROB_RDY=1 is sampled.
  - On PROB_RDY=1 -> WAIT, timer cleared.
  - Waits indefinitely for PROB_RDY.
- WAIT:
  - ANS_EN=1; timer increments each cycle.
  - The first cycle with WL_IN!=00 latches WL_IN -> APPLY.
  - Otherwise, at timer==TIMEOUT_CYC-1, latch 00 -> APPLY (timeout).
  - A nonzero WL_IN on the final timeout cycle takes priority over the timeout.
- WL_IN is ignored in every state except WAIT.
- APPLY (1 cycle):
  - ANS_EN=0; RESULT=latched code; RESULT_VLD=1.
  - 01: EN_HP-=DMG. 10: MY_HP-=DMG. 11: see optional feature. 00: no change.
  - Subtraction saturates at 0.
  - ROUND_CNT+=1, saturating at all-ones.
- CHECK (1 cycle):
  - Any HP==0 -> OVER; else -> GAP.
  - WINNER: EN_HP==0 and MY_HP!=0 -> 01; MY_HP==0 and EN_HP!=0 -> 10; both zero -> 11.
- GAP: GAP_CYC cycles, ANS_EN=0 -> REQ.
- OVER:
  - GAME_OVER=1; HP, WINNER and ROUND_CNT hold.
  - START=1 -> LOAD (GAME_OVER drops on the LOAD cycle).
- START is ignored outside IDLE and OVER.
- Latency: WL_IN nonzero in WAIT at cycle n -> RESULT_VLD and HP update visible at n+2.

Optional Feature:
- Macro: ROUND_CTRL_DRAW_DAMAGE_EN.
- Defined: a draw (11) subtracts DMG from both MY_HP and EN_HP, saturating; a simultaneous knockout gives WINNER=11.
- Undefined: a draw changes no HP, and WINNER=11 is unreachable.

Decomposition:
- Shared package (game_pkg):
  - WL code constants WL_NONE=00, WL_SELF=01, WL_ENEMY=10, WL_DRAW=11.
  - State encoding localparams.
  - WINNER codes.
- One sub-module, round_timer: loadable down-counter with a terminal-count flag, reused for the WAIT timeout and the GAP delay.

Test Plan (HP_INIT=3, DMG=1, TIMEOUT_CYC=16, GAP_CYC=4):
- Reset, START pulse, PROB_RDY 2 cycles after PROB_REQ -> LOAD sets MY_HP=EN_HP=3, ANS_EN=1 in WAIT, PROB_REQ deasserts the cycle after PROB_RDY.
- WL_IN=01 at WAIT cycle 5 -> RESULT=01, RESULT_VLD single pulse 2 cycles later, EN_HP=2, ROUND_CNT=1, next PROB_REQ after 4 GAP cycles.
- WL_IN held 00 -> timeout after 16 WAIT cycles, RESULT=00, HPs unchanged, ROUND_CNT increments.
- Three WL_IN=10 rounds -> MY_HP=0, GAME_OVER=1, WINNER=10. START then reloads HP=3 and ROUND_CNT=0.
- WL_IN=11 -> with the macro both HPs drop by 1, without it no change. With the macro at HP 1/1 -> WINNER=11.
- RST low during WAIT, plus WL_IN toggled in GAP/REQ -> immediate return to IDLE with all outputs 0; WL_IN outside WAIT has no effect.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants for the factorization-battle round sequencer.
// Judge result codes, FSM state encoding and winner codes.
// Imported by round_ctrl and round_timer.
package game_pkg;

  // Judge win/lose codes (WL_IN / RESULT)
  localparam logic [1:0] WL_NONE  = 2'b00;
  localparam logic [1:0] WL_SELF  = 2'b01;
  localparam logic [1:0] WL_ENEMY = 2'b10;
  localparam logic [1:0] WL_DRAW  = 2'b11;

  // Round sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_APPLY = 3'd4;
  localparam logic [2:0] ST_CHECK = 3'd5;
  localparam logic [2:0] ST_GAP   = 3'd6;
  localparam logic [2:0] ST_OVER  = 3'd7;

  // WINNER codes
  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_SELF  = 2'b01;
  localparam logic [1:0] WIN_ENEMY = 2'b10;
  localparam logic [1:0] WIN_BOTH  = 2'b11;

endpackage

// File: rtl/round_timer.sv
// Purpose: loadable down-counter with terminal-count flag (answer window and round gap).
// Latency: load value visible the cycle after load; tc high while count is zero.
// Backpressure: none; load always wins over counting.
// Ports: CLK, RST (async active-low), load, load_val[W], tc.
module round_timer
  import game_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Loading N-1 on entry makes the owning state last exactly N cycles.
  assign tc = (cnt == '0);

endmodule

// File: rtl/round_ctrl.sv
// Purpose: game-round sequencer: request problem, open answer window, apply damage, detect game over.
// Latency: nonzero WL_IN in WAIT at cycle n -> RESULT/RESULT_VLD/HP visible at n+2.
// Backpressure: PROB_REQ held until PROB_RDY; WAIT lasts at most TIMEOUT_CYC cycles.
// Ports: CLK, RST (async active-low), START, PROB_REQ/PROB_RDY handshake, WL_IN judge code,
//        ANS_EN, MY_HP, EN_HP, ROUND_CNT, RESULT, RESULT_VLD, GAME_OVER, WINNER (all registered).
// Build option: define ROUND_CTRL_DRAW_DAMAGE_EN to make a draw damage both players.
module round_ctrl
  import game_pkg::*;
#(
  parameter int HP_W        = 4,
  parameter int HP_INIT     = 5,
  parameter int DMG         = 1,
  parameter int TIMEOUT_CYC = 1024,
  parameter int GAP_CYC     = 8,
  parameter int RND_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic             PROB_REQ,
  input  logic             PROB_RDY,
  input  logic [1:0]       WL_IN,
  output logic             ANS_EN,
  output logic [HP_W-1:0]  MY_HP,
  output logic [HP_W-1:0]  EN_HP,
  output logic [RND_W-1:0] ROUND_CNT,
  output logic [1:0]       RESULT,
  output logic             RESULT_VLD,
  output logic             GAME_OVER,
  output logic [1:0]       WINNER
);

`ifdef ROUND_CTRL_DRAW_DAMAGE_EN
  localparam bit DRAW_DMG = 1'b1;
`else
  localparam bit DRAW_DMG = 1'b0;
`endif

  localparam int TMR_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [HP_W-1:0] DMG_V  = HP_W'(DMG);
  localparam logic [HP_W-1:0] INIT_V = HP_W'(HP_INIT);

  logic [2:0]       state, state_nxt;
  logic [1:0]       wl_lat;
  logic             tmr_load, tmr_tc;
  logic [TMR_W-1:0] tmr_val;
  logic             hit_my, hit_en;
  logic [HP_W-1:0]  my_after, en_after;
  logic [1:0]       win_code;

  round_timer #(.W(TMR_W)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Next state and timer loads. The timer is loaded on the transition into
  // WAIT / GAP so the first cycle of those states already counts.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      ST_IDLE:  if (START) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_REQ;
      ST_REQ: begin
        if (PROB_RDY) begin
          state_nxt = ST_WAIT;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(TIMEOUT_CYC - 1);
        end
      end
      // A nonzero code on the last window cycle still exits here and is latched below.
      ST_WAIT:  if ((WL_IN != WL_NONE) || tmr_tc) state_nxt = ST_APPLY;
      ST_APPLY: state_nxt = ST_CHECK;
      ST_CHECK: begin
        if ((MY_HP == '0) || (EN_HP == '0)) begin
          state_nxt = ST_OVER;
        end else begin
          state_nxt = ST_GAP;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(GAP_CYC - 1);
        end
      end
      ST_GAP:   if (tmr_tc) state_nxt = ST_REQ;
      ST_OVER:  if (START) state_nxt = ST_LOAD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Damage with saturation at zero.
  always_comb begin
    hit_my   = (wl_lat == WL_ENEMY) || (DRAW_DMG && (wl_lat == WL_DRAW));
    hit_en   = (wl_lat == WL_SELF)  || (DRAW_DMG && (wl_lat == WL_DRAW));
    my_after = MY_HP;
    en_after = EN_HP;
    if (hit_my) my_after = (MY_HP > DMG_V) ? (MY_HP - DMG_V) : '0;
    if (hit_en) en_after = (EN_HP > DMG_V) ? (EN_HP - DMG_V) : '0;
  end

  always_comb begin
    win_code = WIN_NONE;
    if ((EN_HP == '0) && (MY_HP != '0))      win_code = WIN_SELF;
    else if ((MY_HP == '0) && (EN_HP != '0)) win_code = WIN_ENEMY;
    else if ((MY_HP == '0) && (EN_HP == '0)) win_code = WIN_BOTH;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      wl_lat     <= WL_NONE;
      PROB_REQ   <= 1'b0;
      ANS_EN     <= 1'b0;
      MY_HP      <= '0;
      EN_HP      <= '0;
      ROUND_CNT  <= '0;
      RESULT     <= WL_NONE;
      RESULT_VLD <= 1'b0;
      GAME_OVER  <= 1'b0;
      WINNER     <= WIN_NONE;
    end else begin
      state      <= state_nxt;
      // Request rises one cycle after REQ entry and drops after the acknowledge.
      PROB_REQ   <= (state == ST_REQ) && !PROB_RDY;
      ANS_EN     <= (state_nxt == ST_WAIT);
      GAME_OVER  <= (state_nxt == ST_OVER);
      RESULT_VLD <= (state == ST_APPLY);

      // The exit cycle's code is what survives; a timeout exit latches 00.
      if (state == ST_WAIT) wl_lat <= WL_IN;

      // Load on the transition so the fresh values are visible in LOAD itself.
      if (state_nxt == ST_LOAD) begin
        MY_HP     <= INIT_V;
        EN_HP     <= INIT_V;
        ROUND_CNT <= '0;
        RESULT    <= WL_NONE;
        WINNER    <= WIN_NONE;
      end

      if (state == ST_APPLY) begin
        RESULT <= wl_lat;
        MY_HP  <= my_after;
        EN_HP  <= en_after;
        if (ROUND_CNT != '1) ROUND_CNT <= ROUND_CNT + 1'b1;
      end

      if ((state == ST_CHECK) && (state_nxt == ST_OVER)) WINNER <= win_code;
    end
  end

endmodule

// File: tb/tb_round_ctrl.sv
// Purpose: self-checking bench for round_ctrl with a round-level reference model.
// Latency: checks request, answer-window, result and gap timing in cycles.
// Backpressure: exercises delayed PROB_RDY acknowledges.
module tb_round_ctrl;

  localparam int HP_W = 4, HP_INIT = 3, DMG = 1, TO = 16, GAP = 4, RND_W = 8;

`ifdef ROUND_CTRL_DRAW_DAMAGE_EN
  localparam bit DRAW_HITS = 1'b1;
`else
  localparam bit DRAW_HITS = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             START = 1'b0;
  logic             PROB_RDY = 1'b0;
  logic [1:0]       WL_IN = 2'b00;
  logic             PROB_REQ, ANS_EN, RESULT_VLD, GAME_OVER;
  logic [HP_W-1:0]  MY_HP, EN_HP;
  logic [RND_W-1:0] ROUND_CNT;
  logic [1:0]       RESULT, WINNER;

  round_ctrl #(
    .HP_W(HP_W), .HP_INIT(HP_INIT), .DMG(DMG),
    .TIMEOUT_CYC(TO), .GAP_CYC(GAP), .RND_W(RND_W)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .PROB_REQ(PROB_REQ), .PROB_RDY(PROB_RDY), .WL_IN(WL_IN),
    .ANS_EN(ANS_EN), .MY_HP(MY_HP), .EN_HP(EN_HP), .ROUND_CNT(ROUND_CNT),
    .RESULT(RESULT), .RESULT_VLD(RESULT_VLD), .GAME_OVER(GAME_OVER), .WINNER(WINNER)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: game-level view of HP, rounds and outcome.
  int m_my, m_en, m_rnd, m_winner;
  bit m_over;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int hit(input int hp);
    return (hp > DMG) ? hp - DMG : 0;
  endfunction

  task automatic model_round(input int code);
    if (code == 1 || (code == 3 && DRAW_HITS)) m_en = hit(m_en);
    if (code == 2 || (code == 3 && DRAW_HITS)) m_my = hit(m_my);
    m_rnd  = (m_rnd < 255) ? m_rnd + 1 : 255;
    m_over = (m_my == 0) || (m_en == 0);
    if (m_my != 0 && m_en == 0)      m_winner = 1;
    else if (m_my == 0 && m_en != 0) m_winner = 2;
    else if (m_my == 0 && m_en == 0) m_winner = 3;
    else                             m_winner = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},  PROB_REQ, 0);
    chk({tag, "_ans"},  ANS_EN, 0);
    chk({tag, "_my"},   MY_HP, 0);
    chk({tag, "_en"},   EN_HP, 0);
    chk({tag, "_rnd"},  ROUND_CNT, 0);
    chk({tag, "_res"},  RESULT, 0);
    chk({tag, "_vld"},  RESULT_VLD, 0);
    chk({tag, "_over"}, GAME_OVER, 0);
    chk({tag, "_win"},  WINNER, 0);
  endtask

  // Leaves the bench at the negedge where PROB_REQ has just risen.
  task automatic start_game();
    int cnt;
    WL_IN = 2'b00;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("load_my", MY_HP, HP_INIT);
    chk("load_en", EN_HP, HP_INIT);
    chk("load_rnd", ROUND_CNT, 0);
    chk("load_res", RESULT, 0);
    chk("load_over", GAME_OVER, 0);
    chk("load_win", WINNER, 0);
    m_my = HP_INIT; m_en = HP_INIT; m_rnd = 0; m_over = 1'b0; m_winner = 0;
    cnt = 0;
    while (!PROB_REQ && cnt < 20) begin
      @(negedge CLK);
      cnt++;
    end
    chk("req_lat", cnt, 2);
  endtask

  // One round: ack after rdy_dly cycles, judge code on answer-window cycle d (ignored for 00).
  task automatic play_round(input int code, input int d, input int rdy_dly);
    int last, cnt;
    for (int k = 0; k < rdy_dly; k++) begin
      WL_IN = 2'($urandom);
      START = 1'($urandom);
      @(negedge CLK);
      chk("req_hold", PROB_REQ, 1);
    end
    PROB_RDY = 1'b1;
    START    = 1'b0;
    WL_IN    = 2'($urandom);
    @(negedge CLK);
    PROB_RDY = 1'b0;
    chk("req_drop", PROB_REQ, 0);
    last = (code == 0) ? TO - 1 : d;
    for (int j = 0; j <= last; j++) begin
      if (j == 0 || j == last) chk("ans_on", ANS_EN, 1);
      WL_IN = (j == last) ? 2'(code) : 2'b00;
      if (j < last) @(negedge CLK);
    end
    @(negedge CLK);
    WL_IN = 2'($urandom);
    chk("ans_off", ANS_EN, 0);
    chk("vld_early", RESULT_VLD, 0);
    @(negedge CLK);
    WL_IN = 2'($urandom);
    model_round(code);
    chk("vld", RESULT_VLD, 1);
    chk("result", RESULT, code);
    chk("my_hp", MY_HP, m_my);
    chk("en_hp", EN_HP, m_en);
    chk("rnd", ROUND_CNT, m_rnd);
    @(negedge CLK);
    chk("vld_pulse", RESULT_VLD, 0);
    chk("over", GAME_OVER, m_over);
    chk("winner", WINNER, m_winner);
    if (!m_over) begin
      cnt = 1;
      while (!PROB_REQ && cnt < 20) begin
        WL_IN = 2'($urandom);
        START = 1'($urandom);
        @(negedge CLK);
        cnt++;
      end
      START = 1'b0;
      chk("gap_len", cnt, GAP + 2);
    end else begin
      repeat (3) begin
        WL_IN = 2'($urandom);
        @(negedge CLK);
      end
      chk("over_hold", GAME_OVER, 1);
      chk("over_win", WINNER, m_winner);
      chk("over_my", MY_HP, m_my);
      chk("over_rnd", ROUND_CNT, m_rnd);
      chk("over_noreq", PROB_REQ, 0);
    end
  endtask

  task automatic random_until_over();
    int guard;
    guard = 0;
    while (!m_over && guard < 40) begin
      play_round($urandom_range(0, 3), $urandom_range(0, TO - 1), $urandom_range(0, 3));
      guard++;
    end
    chk("game_end", m_over, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    check_all_zero("rst");
    RST = 1'b1;
    repeat (3) begin
      WL_IN = 2'($urandom);
      @(negedge CLK);
    end
    chk("idle_noreq", PROB_REQ, 0);
    chk("idle_my", MY_HP, 0);

    // Game 1: directed start, then enemy wins until knockout.
    start_game();
    play_round(1, 5, 2);
    play_round(0, 0, 1);
    play_round(3, $urandom_range(0, TO - 1), $urandom_range(0, 3));
    for (int g = 0; g < 10 && !m_over; g++)
      play_round(2, $urandom_range(0, TO - 1), $urandom_range(0, 3));
    chk("g1_winner", m_winner, 2);

    // Game 2: restart from OVER; nonzero code on final window cycle beats timeout.
    start_game();
    play_round(2, TO - 1, 0);
    random_until_over();

    // Game 3: walk both HPs to 1 and finish with a draw.
    start_game();
    play_round(1, 0, 0);
    play_round(2, 3, 1);
    play_round(1, 7, 0);
    play_round(2, 1, 2);
    play_round(3, 4, 0);
    if (!m_over) random_until_over();

    // Reset in the middle of an answer window.
    start_game();
    PROB_RDY = 1'b1;
    @(negedge CLK);
    PROB_RDY = 1'b0;
    chk("rst_wait_ans", ANS_EN, 1);
    WL_IN = 2'b00;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge CLK);
    RST = 1'b1;
    repeat (8) begin
      WL_IN    = 2'($urandom);
      PROB_RDY = 1'($urandom);
      @(negedge CLK);
    end
    PROB_RDY = 1'b0;
    check_all_zero("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
